// File: rtl/cu_pipe.sv
// cu_pipe: SPARC decode plus EX/MEM/WB control-bundle pipeline.
//
// Decodes the instruction presented in the decode stage into a 26-bit control
// bundle. The bundle then advances through three registered stages (EX, MEM,
// WB), with a load-use hazard detector that inserts a bubble into EX.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high; clears all stage state
//   instr        32-bit instruction in decode
//   instr_valid  instr is a real instruction
//   stall_in     external freeze; all stage registers hold
//   flush_in     kill the decode-stage instruction
//   ctrl_ex/mem/wb   registered control bundles
//   valid_ex/mem/wb  stage holds a live instruction
//   stall_out    load-use hazard; upstream holds instr
//   illegal      decode-stage instr unrecognised (combinational)
//
// Bundle: [25:21] rd, [20:17] alu_op, [16:13] soh_op, [12] rw, [11] e,
//         [10:9] size, [8] se, [7] l, [6] cc_we, [5] rf_le, [4] j_l,
//         [3] call, [2] b, [1] use_cc, [0] annul
module cu_pipe #(
  parameter bit EXT_ALU   = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic [25:0] ctrl_ex,
  output logic [25:0] ctrl_mem,
  output logic [25:0] ctrl_wb,
  output logic        valid_ex,
  output logic        valid_mem,
  output logic        valid_wb,
  output logic        stall_out,
  output logic        illegal
);

  // An unrecognised instruction keeps only the default word size.
  localparam logic [25:0] IllBundle = 26'h0000400;

  logic [1:0]  op;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic        i_bit;
  logic [25:0] dec;
  logic        unknown;

  assign op    = instr[31:30];
  assign op2   = instr[24:22];
  assign op3   = instr[24:19];
  assign i_bit = instr[13];

  always_comb begin
    dec          = '0;
    dec[10:9]    = 2'b10;
    dec[25:21]   = instr[29:25];
    unknown      = 1'b0;
    unique case (op)
      2'b01: begin
        dec[3]     = 1'b1;
        dec[5]     = 1'b1;
        dec[25:21] = 5'd15;
      end
      2'b00: begin
        case (op2)
          3'b010: begin
            dec[2] = 1'b1;
            dec[1] = 1'b1;
            dec[0] = instr[29];
          end
          3'b100: begin
            dec[5]     = 1'b1;
            dec[16:13] = 4'b0010;
            dec[20:17] = 4'b1101;
          end
          default: unknown = 1'b1;
        endcase
      end
      2'b10: begin
        dec[16:13] = {3'b000, i_bit};
        case (op3)
          6'b111000: begin
            dec[4] = 1'b1;
            dec[5] = 1'b1;
          end
          6'b000000, 6'b010000: begin
            dec[20:17] = 4'b0000;
            dec[5]     = 1'b1;
            dec[6]     = op3[4];
          end
          6'b000100, 6'b010100: begin
            dec[20:17] = 4'b0010;
            dec[5]     = 1'b1;
            dec[6]     = op3[4];
          end
          6'b000001, 6'b010001,
          6'b000010, 6'b010010,
          6'b000011, 6'b010011: begin
            if (EXT_ALU) begin
              // and/or/xor map onto consecutive ALU codes 0100..0110.
              dec[20:17] = 4'b0011 + {2'b00, op3[1:0]};
              dec[5]     = 1'b1;
              dec[6]     = op3[4];
            end else begin
              unknown = 1'b1;
            end
          end
          default: unknown = 1'b1;
        endcase
      end
      2'b11: begin
        dec[16:13] = {3'b000, i_bit};
        dec[11]    = 1'b1;
        case (op3)
          6'b000001: begin dec[7] = 1'b1; dec[5] = 1'b1; dec[10:9] = 2'b00; end
          6'b001001: begin dec[7] = 1'b1; dec[5] = 1'b1; dec[10:9] = 2'b00; dec[8] = 1'b1; end
          6'b000010: begin dec[7] = 1'b1; dec[5] = 1'b1; dec[10:9] = 2'b01; end
          6'b001010: begin dec[7] = 1'b1; dec[5] = 1'b1; dec[10:9] = 2'b01; dec[8] = 1'b1; end
          6'b000000: begin dec[7] = 1'b1; dec[5] = 1'b1; dec[10:9] = 2'b10; end
          6'b000101: begin dec[12] = 1'b1; dec[10:9] = 2'b00; end
          6'b000110: begin dec[12] = 1'b1; dec[10:9] = 2'b01; end
          6'b000100: begin dec[12] = 1'b1; dec[10:9] = 2'b10; end
          default: unknown = 1'b1;
        endcase
      end
      default: unknown = 1'b1;
    endcase
    if (unknown) begin
      dec = IllBundle;
    end
  end

  assign illegal = unknown & instr_valid;

  // Load-use hazard against the instruction currently in EX.
  logic [4:0] ex_rd;
  logic       is_store;
  logic       src_match;
  logic       hazard_raw;
  logic       hazard;

  assign ex_rd     = ctrl_ex[25:21];
  assign is_store  = dec[12];
  assign src_match = (ex_rd == instr[18:14]) ||
                     (!i_bit && (ex_rd == instr[4:0])) ||
                     (is_store && (ex_rd == instr[29:25]));
  assign hazard_raw = valid_ex & ctrl_ex[7] & (|ex_rd) & instr_valid & ~flush_in & src_match;
  assign hazard     = HAZARD_EN & hazard_raw;
  assign stall_out  = hazard & ~stall_in;

  logic take;
  assign take = instr_valid & ~flush_in & ~hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_ex   <= '0;
      ctrl_mem  <= '0;
      ctrl_wb   <= '0;
      valid_ex  <= 1'b0;
      valid_mem <= 1'b0;
      valid_wb  <= 1'b0;
    end else if (!stall_in) begin
      ctrl_wb   <= ctrl_mem;
      valid_wb  <= valid_mem;
      ctrl_mem  <= ctrl_ex;
      valid_mem <= valid_ex;
      // Dead slots always carry a zero bundle.
      ctrl_ex   <= take ? dec : '0;
      valid_ex  <= take;
    end
  end

endmodule

// File: tb/tb_cu_pipe.sv
module tb_cu_pipe;

  typedef struct packed {
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic [3:0] soh_op;
    logic       rw;
    logic       e;
    logic [1:0] size;
    logic       se;
    logic       l;
    logic       cc_we;
    logic       rf_le;
    logic       j_l;
    logic       call;
    logic       b;
    logic       use_cc;
    logic       annul;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;

  logic [25:0] ctrl_ex, ctrl_mem, ctrl_wb;
  logic        valid_ex, valid_mem, valid_wb, stall_out, illegal;
  logic [25:0] nx_ex, nx_mem, nx_wb;
  logic        nx_vex, nx_vmem, nx_vwb, nx_stall, nx_ill;
  logic [25:0] nh_ex, nh_mem, nh_wb;
  logic        nh_vex, nh_vmem, nh_vwb, nh_stall, nh_ill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cu_pipe #(.EXT_ALU(1'b1), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .stall_in(stall_in), .flush_in(flush_in),
    .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .ctrl_wb(ctrl_wb),
    .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
    .stall_out(stall_out), .illegal(illegal)
  );

  cu_pipe #(.EXT_ALU(1'b0), .HAZARD_EN(1'b1)) dut_noext (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .stall_in(stall_in), .flush_in(flush_in),
    .ctrl_ex(nx_ex), .ctrl_mem(nx_mem), .ctrl_wb(nx_wb),
    .valid_ex(nx_vex), .valid_mem(nx_vmem), .valid_wb(nx_vwb),
    .stall_out(nx_stall), .illegal(nx_ill)
  );

  cu_pipe #(.EXT_ALU(1'b1), .HAZARD_EN(1'b0)) dut_nohaz (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .stall_in(stall_in), .flush_in(flush_in),
    .ctrl_ex(nh_ex), .ctrl_mem(nh_mem), .ctrl_wb(nh_wb),
    .valid_ex(nh_vex), .valid_mem(nh_vmem), .valid_wb(nh_vwb),
    .stall_out(nh_stall), .illegal(nh_ill)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set tables.
  function automatic ctl_t ref_dec(input logic [31:0] w, input bit ext, output bit bad);
    ctl_t c;
    logic [5:0] op3, base;
    c = '0;
    c.size = 2'b10;
    c.rd = w[29:25];
    bad = 1'b0;
    op3 = w[24:19];
    base = op3 & 6'b101111;
    case (w[31:30])
      2'd1: begin c.call = 1; c.rf_le = 1; c.rd = 5'd15; end
      2'd0: begin
        if (w[24:22] == 3'd2) begin c.b = 1; c.use_cc = 1; c.annul = w[29]; end
        else if (w[24:22] == 3'd4) begin c.rf_le = 1; c.soh_op = 4'd2; c.alu_op = 4'd13; end
        else bad = 1'b1;
      end
      2'd2: begin
        c.soh_op = w[13] ? 4'd1 : 4'd0;
        if (op3 == 6'o70) begin c.j_l = 1; c.rf_le = 1; end
        else if (base == 0 || base == 4 || (ext && (base == 1 || base == 2 || base == 3))) begin
          case (base)
            6'd0: c.alu_op = 4'd0;
            6'd4: c.alu_op = 4'd2;
            6'd1: c.alu_op = 4'd4;
            6'd2: c.alu_op = 4'd5;
            default: c.alu_op = 4'd6;
          endcase
          c.rf_le = 1;
          c.cc_we = op3[4];
        end else bad = 1'b1;
      end
      default: begin
        c.soh_op = w[13] ? 4'd1 : 4'd0;
        c.e = 1;
        case (op3)
          6'o01: begin c.l = 1; c.rf_le = 1; c.size = 0; end
          6'o11: begin c.l = 1; c.rf_le = 1; c.size = 0; c.se = 1; end
          6'o02: begin c.l = 1; c.rf_le = 1; c.size = 1; end
          6'o12: begin c.l = 1; c.rf_le = 1; c.size = 1; c.se = 1; end
          6'o00: begin c.l = 1; c.rf_le = 1; c.size = 2; end
          6'o05: begin c.rw = 1; c.size = 0; end
          6'o06: begin c.rw = 1; c.size = 1; end
          6'o04: begin c.rw = 1; c.size = 2; end
          default: bad = 1'b1;
        endcase
      end
    endcase
    if (bad) begin
      c = '0;
      c.size = 2'b10;
    end
    return c;
  endfunction

  // Pipeline model: index 0=EX, 1=MEM, 2=WB.
  ctl_t m[3];
  bit   mv[3];
  bit   last_stall, last_ill, last_stall_nh, last_ill_nx, last_haz;

  task automatic check_regs(input string tag);
    check_eq({tag, ".ex"},  ctrl_ex,  m[0]);
    check_eq({tag, ".mem"}, ctrl_mem, m[1]);
    check_eq({tag, ".wb"},  ctrl_wb,  m[2]);
    check_eq({tag, ".valid"}, {valid_ex, valid_mem, valid_wb}, {mv[0], mv[1], mv[2]});
  endtask

  task automatic step(input logic [31:0] w, input bit v, input bit st, input bit fl,
                      input bit rs);
    ctl_t d, dn;
    bit bad, badn, haz;
    @(negedge clk);
    instr = w; instr_valid = v; stall_in = st; flush_in = fl; reset = rs;
    #1;
    if (rs) begin
      for (int k = 0; k < 3; k++) begin m[k] = '0; mv[k] = 0; end
      check_regs("reset_async");
    end
    d  = ref_dec(w, 1'b1, bad);
    dn = ref_dec(w, 1'b0, badn);
    haz = mv[0] && m[0].l && (m[0].rd != 0) && v && !fl &&
          ((m[0].rd == w[18:14]) || (!w[13] && m[0].rd == w[4:0]) ||
           (d.rw && m[0].rd == w[29:25]));
    last_haz = haz;
    last_stall = stall_out; last_ill = illegal;
    last_stall_nh = nh_stall; last_ill_nx = nx_ill;
    check_eq("stall_out", stall_out, haz && !st);
    check_eq("illegal", illegal, bad && v);
    check_eq("illegal_noext", nx_ill, badn && v);
    check_eq("stall_nohaz", nh_stall, 1'b0);
    @(posedge clk);
    #1;
    if (!rs && !st) begin
      m[2] = m[1]; mv[2] = mv[1];
      m[1] = m[0]; mv[1] = mv[0];
      if (!haz && v && !fl) begin m[0] = d; mv[0] = 1; end
      else begin m[0] = '0; mv[0] = 0; end
    end
    check_regs("pipe");
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0] rd, rs1, rs2;
    logic [5:0] op3;
    int r;
    rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    r = $urandom_range(0, 9);
    case (r)
      0: return {2'b01, 30'($urandom)};
      1: return {2'b00, 5'($urandom), 3'b010, 22'($urandom)};
      2: return {2'b00, rd, 3'b100, 22'($urandom)};
      3, 4: begin
        case ($urandom_range(0, 11))
          0: op3 = 6'o00; 1: op3 = 6'o04; 2: op3 = 6'o20; 3: op3 = 6'o24;
          4: op3 = 6'o01; 5: op3 = 6'o02; 6: op3 = 6'o03; 7: op3 = 6'o21;
          8: op3 = 6'o22; 9: op3 = 6'o23; 10: op3 = 6'o70;
          default: op3 = 6'($urandom);
        endcase
        return {2'b10, rd, op3, rs1, 1'($urandom), 8'($urandom), rs2};
      end
      5, 6, 7: begin
        case ($urandom_range(0, 8))
          0: op3 = 6'o01; 1: op3 = 6'o11; 2: op3 = 6'o02; 3: op3 = 6'o12;
          4: op3 = 6'o00; 5: op3 = 6'o05; 6: op3 = 6'o06; 7: op3 = 6'o04;
          default: op3 = 6'($urandom);
        endcase
        return {2'b11, rd, op3, rs1, 1'($urandom), 8'($urandom), rs2};
      end
      8: return {2'b00, 5'($urandom), 3'($urandom), 22'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] AddG3 = 32'h86004002;
  localparam logic [31:0] LdG4  = 32'hC8006000;
  localparam logic [31:0] AddG6 = 32'h8C014004;

  initial begin
    logic [31:0] cur;
    bit hold;
    for (int k = 0; k < 3; k++) begin m[k] = '0; mv[k] = 0; end
    step(32'h0, 0, 0, 0, 1);
    check_eq("reset_valid", {valid_ex, valid_mem, valid_wb}, 3'b000);

    // Single add flows to WB in three cycles.
    step(AddG3, 1, 0, 0, 0);
    check_eq("add.valid_ex", valid_ex, 1'b1);
    check_eq("add.rd", ctrl_ex[25:21], 5'd3);
    check_eq("add.alu_op", ctrl_ex[20:17], 4'd0);
    check_eq("add.rf_le", ctrl_ex[5], 1'b1);
    check_eq("add.cc_we", ctrl_ex[6], 1'b0);
    step(32'h0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0);
    check_eq("add.wb", ctrl_wb, 26'h0600420);
    check_eq("add.valid_wb", valid_wb, 1'b1);

    // Load-use: one bubble, then the held add enters EX.
    step(LdG4, 1, 0, 0, 0);
    step(AddG6, 1, 0, 0, 0);
    check_eq("lu.stall", last_stall, 1'b1);
    check_eq("lu.stall_nohaz", last_stall_nh, 1'b0);
    check_eq("lu.bubble_valid", valid_ex, 1'b0);
    check_eq("lu.bubble_ctrl", ctrl_ex, 26'h0);
    check_eq("lu.ld_in_mem", valid_mem, 1'b1);
    step(AddG6, 1, 0, 0, 0);
    check_eq("lu.stall2", last_stall, 1'b0);
    check_eq("lu.add_ex", {valid_ex, ctrl_ex[25:21]}, {1'b1, 5'd6});

    // Flush beats the hazard.
    step(LdG4, 1, 0, 0, 0);
    step(AddG6, 1, 0, 1, 0);
    check_eq("fl.stall", last_stall, 1'b0);
    check_eq("fl.valid_ex", valid_ex, 1'b0);

    // Annulled branch and an illegal format-3 op.
    step(32'h30800004, 1, 0, 0, 0);
    check_eq("ba.b_cc_annul", ctrl_ex[2:0], 3'b111);
    step(32'h81C80000, 1, 0, 0, 0);
    check_eq("ill.flag", last_ill, 1'b1);
    check_eq("ill.rf_le", {valid_ex, ctrl_ex[5]}, 2'b10);

    // External stall with three live stages, then reset mid-stall.
    step(32'h80004002 | (32'd1 << 25), 1, 0, 0, 0);
    step(32'h80004002 | (32'd2 << 25), 1, 0, 0, 0);
    step(32'h80004002 | (32'd3 << 25), 1, 0, 0, 0);
    step(LdG4, 1, 1, 0, 0);
    step(LdG4, 1, 1, 1, 0);
    check_eq("st.rd", {ctrl_ex[25:21], ctrl_mem[25:21], ctrl_wb[25:21]},
             {5'd3, 5'd2, 5'd1});
    check_eq("st.valid", {valid_ex, valid_mem, valid_wb}, 3'b111);
    step(LdG4, 1, 1, 0, 1);
    check_eq("rst_mid_stall", {valid_ex, valid_mem, valid_wb}, 3'b000);
    step(32'h0, 0, 0, 0, 0);

    // Extended ALU op with EXT_ALU disabled.
    step(32'h82084002, 1, 0, 0, 0);
    check_eq("noext.and_illegal", last_ill_nx, 1'b1);
    check_eq("ext.and_legal", last_ill, 1'b0);
    check_eq("ext.and_alu", ctrl_ex[20:17], 4'd4);

    // Randomized run against the model.
    cur = gen_instr();
    for (int n = 0; n < 3000; n++) begin
      hold = last_haz && ($urandom_range(0, 9) < 7);
      if (!hold) cur = gen_instr();
      if ($urandom_range(0, 99) == 0) begin
        step(cur, 1, 0, 0, 1);
      end else begin
        step(cur, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 10, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
